// File: rtl/nonce_result_scanner.sv
// Scans the per-nonce final-hash words left by the hasher, tracks the first passing
// nonce and the minimum hash, and writes a two-word result record back to memory.
`timescale 1ns/1ps

module nonce_result_scanner #(
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned IDX_W      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] out_base,
  input  logic [15:0] result_addr,
  input  logic [31:0] nonce_base,
  input  logic [31:0] target,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic [31:0] min_hash,
  output logic [31:0] min_nonce
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WR0   = 3'd3,
    WR1   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] ev_idx;
  logic             ev_valid;
  logic [15:0]      result_addr_q;
  logic [31:0]      nonce_base_q;
  logic [31:0]      target_q;

  logic [31:0]      ev_nonce;
  logic             found_nx;
  logic [31:0]      found_nonce_nx;
  logic [31:0]      min_hash_nx;
  logic [31:0]      min_nonce_nx;

  assign mem_clk = clk;

  // Evaluate the word returned for the read issued last cycle; index 0 always seeds the minimum.
  always_comb begin
    found_nx       = found;
    found_nonce_nx = found_nonce;
    min_hash_nx    = min_hash;
    min_nonce_nx   = min_nonce;
    ev_nonce       = nonce_base_q + 32'(ev_idx);
    if (ev_valid) begin
      if (!found && (mem_read_data < target_q)) begin
        found_nx       = 1'b1;
        found_nonce_nx = ev_nonce;
      end
      if ((ev_idx == '0) || (mem_read_data < min_hash)) begin
        min_hash_nx  = mem_read_data;
        min_nonce_nx = ev_nonce;
      end
    end
  end

  // Control FSM with registered memory interface and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rd_idx         <= '0;
      ev_idx         <= '0;
      ev_valid       <= 1'b0;
      result_addr_q  <= '0;
      nonce_base_q   <= '0;
      target_q       <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      done           <= 1'b0;
      found          <= 1'b0;
      found_nonce    <= '0;
      min_hash       <= 32'hFFFF_FFFF;
      min_nonce      <= '0;
    end else begin
      done        <= 1'b0;
      mem_we      <= 1'b0;
      ev_valid    <= 1'b0;
      found       <= found_nx;
      found_nonce <= found_nonce_nx;
      min_hash    <= min_hash_nx;
      min_nonce   <= min_nonce_nx;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= READ;
            mem_addr      <= out_base;
            rd_idx        <= '0;
            result_addr_q <= result_addr;
            nonce_base_q  <= nonce_base;
            target_q      <= target;
            found         <= 1'b0;
            min_hash      <= 32'hFFFF_FFFF;
          end
        end
        READ: begin
          ev_valid <= 1'b1;
          ev_idx   <= rd_idx;
          if (rd_idx == LAST_IDX) begin
            state <= DRAIN;
          end else begin
            rd_idx   <= rd_idx + IDX_W'(1);
            mem_addr <= mem_addr + 16'd1;
          end
        end
        DRAIN: begin
          // Final word is folded in here, so the record uses the next-state results.
          state          <= WR0;
          mem_we         <= 1'b1;
          mem_addr       <= result_addr_q;
          mem_write_data <= found_nx ? found_nonce_nx : 32'hFFFF_FFFF;
        end
        WR0: begin
          state          <= WR1;
          mem_we         <= 1'b1;
          mem_addr       <= result_addr_q + 16'd1;
          mem_write_data <= min_hash;
        end
        WR1: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Directed bench for nonce_result_scanner with a synchronous single-port memory model.
`timescale 1ns/1ps

module tb_nonce_result_scanner;

  localparam int N = 16;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] out_base;
  logic [15:0] result_addr;
  logic [31:0] nonce_base;
  logic [31:0] target;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        done;
  logic        found;
  logic [31:0] found_nonce;
  logic [31:0] min_hash;
  logic [31:0] min_nonce;

  logic        ld_en;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] mem [0:65535];

  int total;
  int bad;

  nonce_result_scanner dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .out_base       (out_base),
    .result_addr    (result_addr),
    .nonce_base     (nonce_base),
    .target         (target),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .done           (done),
    .found          (found),
    .found_nonce    (found_nonce),
    .min_hash       (min_hash),
    .min_nonce      (min_nonce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous memory; the bench preloads words through the ld_* port.
  always @(posedge mem_clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  task automatic load(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic run_scan(input logic [15:0] ob, input logic [15:0] ra, input logic [31:0] nb,
                          input logic [31:0] tgt, input int glitch,
                          output int lat, output logic addr_ok);
    int cnt;
    @(negedge clk);
    out_base = ob; result_addr = ra; nonce_base = nb; target = tgt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cnt = 0; addr_ok = 1'b1; lat = -1;
    if (mem_addr !== ob) addr_ok = 1'b0;
    while (cnt < 100 && lat < 0) begin
      if (cnt == glitch) begin
        start = 1'b1; target = 32'h0; out_base = 16'h0; nonce_base = 32'h0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cnt++;
      if (cnt < N && mem_addr !== 16'(ob + 16'(cnt))) addr_ok = 1'b0;
      if (done) lat = cnt;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0b want=0", mem_we); end
    total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0000", mem_addr); end
    total++; if (mem_write_data !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", mem_write_data); end
    total++; if (done !== 1'b0 || found !== 1'b0) begin bad++; $display("FAIL reset_flags got done=%0b found=%0b want 0/0", done, found); end
    total++; if (found_nonce !== 32'h0 || min_nonce !== 32'h0) begin bad++; $display("FAIL reset_nonces got=%h/%h want 0/0", found_nonce, min_nonce); end
    total++; if (min_hash !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_min_hash got=%h want=ffffffff", min_hash); end
  endtask

  task automatic load_basic;
    for (int i = 0; i < N; i++) load(16'(16'h0100 + i), (i == 5) ? 32'h0000_0042 : 32'h1000_0000 + 32'(i));
  endtask

  task automatic test_basic;
    int lat; logic aok;
    load_basic();
    run_scan(16'h0100, 16'h0200, 32'h0, 32'h0000_1000, -1, lat, aok);
    total++; if (lat !== 19) begin bad++; $display("FAIL basic_latency got=%0d want=19", lat); end
    total++; if (aok !== 1'b1) begin bad++; $display("FAIL basic_read_addr got=bad_seq want=out_base+i"); end
    total++; if (found !== 1'b1 || found_nonce !== 32'd5) begin bad++; $display("FAIL basic_found got=%0b/%h want=1/00000005", found, found_nonce); end
    total++; if (min_hash !== 32'h42 || min_nonce !== 32'd5) begin bad++; $display("FAIL basic_min got=%h/%h want=00000042/00000005", min_hash, min_nonce); end
    total++; if (mem[16'h0200] !== 32'd5 || mem[16'h0201] !== 32'h42) begin bad++; $display("FAIL basic_record got=%h/%h want=00000005/00000042", mem[16'h0200], mem[16'h0201]); end
  endtask

  task automatic test_multi_pass;
    int lat; logic aok;
    for (int i = 0; i < N; i++) load(16'(16'h0400 + i), (i == 3) ? 32'd10 : (i == 9) ? 32'd5 : 32'hFFFF_FFFF);
    run_scan(16'h0400, 16'h0500, 32'h0000_0100, 32'd100, -1, lat, aok);
    total++; if (lat !== 19) begin bad++; $display("FAIL multi_latency got=%0d want=19", lat); end
    total++; if (found !== 1'b1 || found_nonce !== 32'h103) begin bad++; $display("FAIL multi_found got=%0b/%h want=1/00000103", found, found_nonce); end
    total++; if (min_hash !== 32'd5 || min_nonce !== 32'h109) begin bad++; $display("FAIL multi_min got=%h/%h want=00000005/00000109", min_hash, min_nonce); end
    total++; if (mem[16'h0500] !== 32'h103 || mem[16'h0501] !== 32'd5) begin bad++; $display("FAIL multi_record got=%h/%h want=00000103/00000005", mem[16'h0500], mem[16'h0501]); end
  endtask

  task automatic test_no_pass;
    int lat; logic aok;
    logic [31:0] h [16];
    h = '{32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0ABC_DEF0,
          32'h0000_9999, 32'h7777_7777, 32'h0000_0500, 32'hDEAD_BEEF,
          32'h0000_0124, 32'h4000_0000, 32'h0100_0000, 32'h0000_0123,
          32'h0000_0123, 32'hFFFF_0000, 32'h0000_0200, 32'h3333_3333};
    for (int i = 0; i < N; i++) load(16'(16'h0600 + i), h[i]);
    run_scan(16'h0600, 16'h0700, 32'h0000_1000, 32'h0, -1, lat, aok);
    total++; if (found !== 1'b0) begin bad++; $display("FAIL nopass_found got=%0b want=0", found); end
    total++; if (min_hash !== 32'h123 || min_nonce !== 32'h100B) begin bad++; $display("FAIL nopass_min got=%h/%h want=00000123/0000100b", min_hash, min_nonce); end
    total++; if (mem[16'h0700] !== 32'hFFFF_FFFF || mem[16'h0701] !== 32'h123) begin bad++; $display("FAIL nopass_record got=%h/%h want=ffffffff/00000123", mem[16'h0700], mem[16'h0701]); end
    for (int i = 0; i < N; i++) load(16'(16'h0600 + i), 32'hFFFF_FFFF);
    run_scan(16'h0600, 16'h0700, 32'h0000_0055, 32'h0, -1, lat, aok);
    total++; if (min_hash !== 32'hFFFF_FFFF || min_nonce !== 32'h55) begin bad++; $display("FAIL allff_min got=%h/%h want=ffffffff/00000055", min_hash, min_nonce); end
  endtask

  task automatic test_ties_wrap;
    int lat; logic aok;
    for (int i = 0; i < N; i++) load(16'(16'hFFF8 + i), 32'd7);
    run_scan(16'hFFF8, 16'hFFFF, 32'hFFFF_FFFE, 32'd8, -1, lat, aok);
    total++; if (aok !== 1'b1) begin bad++; $display("FAIL wrap_read_addr got=bad_seq want=fff8..0007"); end
    total++; if (found_nonce !== 32'hFFFF_FFFE || min_nonce !== 32'hFFFF_FFFE) begin bad++; $display("FAIL ties_nonce got=%h/%h want=fffffffe/fffffffe", found_nonce, min_nonce); end
    total++; if (mem[16'hFFFF] !== 32'hFFFF_FFFE || mem[16'h0000] !== 32'd7) begin bad++; $display("FAIL wrap_record got=%h/%h want=fffffffe/00000007", mem[16'hFFFF], mem[16'h0000]); end
  endtask

  task automatic test_ignored_start;
    int lat; logic aok; int pulses;
    load_basic();
    run_scan(16'h0100, 16'h0800, 32'h0, 32'h0000_1000, 4, lat, aok);
    total++; if (lat !== 19) begin bad++; $display("FAIL ign_latency got=%0d want=19", lat); end
    pulses = 1;
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ign_done_width got=%0b want=0", done); end
    for (int i = 0; i < 25; i++) begin @(posedge clk); #1; if (done) pulses++; end
    total++; if (pulses !== 1) begin bad++; $display("FAIL ign_pulses got=%0d want=1", pulses); end
    total++; if (found !== 1'b1 || found_nonce !== 32'd5 || min_hash !== 32'h42) begin bad++; $display("FAIL ign_hold got=%0b/%h/%h want=1/00000005/00000042", found, found_nonce, min_hash); end
  endtask

  task automatic test_reset_mid;
    int lat; logic aok;
    load(16'h0300, 32'hDEAD_BEEF);
    @(negedge clk);
    out_base = 16'h0100; result_addr = 16'h0300; nonce_base = 32'h0; target = 32'h0000_1000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (N + 1) @(posedge clk);
    #1;
    total++; if (mem_we !== 1'b1 || mem_addr !== 16'h0300) begin bad++; $display("FAIL rst_wr0_entry got=%0b/%h want=1/0300", mem_we, mem_addr); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_async_we got=%0b want=0", mem_we); end
    total++; if (found !== 1'b0 || min_hash !== 32'hFFFF_FFFF || found_nonce !== 32'h0 || min_nonce !== 32'h0 || mem_addr !== 16'h0 || done !== 1'b0)
      begin bad++; $display("FAIL rst_outputs got=%0b/%h/%h/%h/%h want=0/ffffffff/0/0/0000", found, min_hash, found_nonce, min_nonce, mem_addr); end
    @(negedge clk);
    reset_n = 1'b1;
    total++; if (mem[16'h0300] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rst_no_write got=%h want=deadbeef", mem[16'h0300]); end
    run_scan(16'h0100, 16'h0300, 32'h0, 32'h0000_1000, -1, lat, aok);
    total++; if (lat !== 19 || mem[16'h0300] !== 32'd5 || mem[16'h0301] !== 32'h42) begin bad++; $display("FAIL rst_rerun got=%0d/%h/%h want=19/00000005/00000042", lat, mem[16'h0300], mem[16'h0301]); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; start = 1'b0; out_base = '0; result_addr = '0; nonce_base = '0; target = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_basic();
    test_multi_pass();
    test_no_pass();
    test_ties_wrap();
    test_ignored_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
